// File: rtl/multiplicador_seq_4bits.sv
// ----------------------------------------------------------------------------
// multiplicador_seq_4bits
//   Sequential shift-and-add unit computing A = Q*B + R. It is the check path
//   for the divider: feeding the quotient/divisor/remainder back through it
//   must rebuild the original dividend. With R = 0 it is a plain multiplier.
//   One multiplier bit is retired per clock, so an operation takes N+2 cycles
//   (accept, N steps, done).
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   operation request, only looked at while idle
//   Q      in   [N-1:0]  multiplier (quotient)
//   B      in   [N-1:0]  multiplicand (divisor)
//   R      in   [N-1:0]  addend (remainder)
//   busy   out  high while the add/shift steps are running
//   done   out  one-cycle pulse; A and FIT are valid from this cycle on
//   A      out  [2N-1:0] registered result Q*B+R
//   FIT    out  1 when A fits in N bits (upper half zero)
// ----------------------------------------------------------------------------
module multiplicador_seq_4bits #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   Q,
    input  logic [N-1:0]   B,
    input  logic [N-1:0]   R,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] A,
    output logic           FIT
);

    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [2*N-1:0]   mcand;   // multiplicand, shifted left each step
    logic [N-1:0]     mplier;  // multiplier, shifted right each step
    logic [2*N-1:0]   acc;     // starts at R so the addend costs no extra cycle
    logic [CNT_W-1:0] cnt;

    // Accumulator value after the current step. The result never exceeds
    // 2^2N - 2^N, so dropping the carry-out is safe.
    logic [2*N-1:0]   acc_step;

    always_comb begin
        acc_step = acc;
        if (mplier[0])
            acc_step = acc + mcand;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            A      <= '0;
            FIT    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand  <= {{N{1'b0}}, B};
                        mplier <= Q;
                        acc    <= {{N{1'b0}}, R};
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= CALC;
                    end else begin
                        busy   <= 1'b0;
                    end
                end

                CALC: begin
                    acc    <= acc_step;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_STEP) begin
                        // Publish straight from the step result so done and
                        // A line up on the same cycle.
                        A     <= acc_step;
                        FIT   <= (acc_step[2*N-1:N] == '0);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end

                DONE: begin
                    // start is deliberately ignored here; no request queuing.
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiplicador_seq_4bits.sv
module tb_multiplicador_seq_4bits;

    localparam int N = 4;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [N-1:0]   Q, B, R;
    logic           busy, done;
    logic [2*N-1:0] A;
    logic           FIT;

    int checks = 0;
    int errors = 0;

    multiplicador_seq_4bits #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .Q     (Q),
        .B     (B),
        .R     (R),
        .busy  (busy),
        .done  (done),
        .A     (A),
        .FIT   (FIT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain arithmetic.
    function automatic int model_a(input int q, input int b, input int r);
        return q * b + r;
    endfunction

    function automatic bit model_fit(input int q, input int b, input int r);
        return (q * b + r) < (1 << N);
    endfunction

    // Issue one operation and collect what the DUT produced. No checking here.
    task automatic run_op(input int q, input int b, input int r,
                          output int a_o, output bit fit_o, output int lat,
                          output int busy_cyc, output bit tail_done);
        int cyc;
        @(negedge clk);
        Q = N'(q); B = N'(b); R = N'(r); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0; busy_cyc = 0;
        while (!done && cyc < 20) begin
            if (busy) busy_cyc++;
            @(posedge clk); #1;
            cyc++;
        end
        lat = cyc;
        a_o = int'(A);
        fit_o = FIT;
        @(posedge clk); #1;
        tail_done = done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; Q = '0; B = '0; R = '0;
        #12;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || A !== 8'h00 || FIT !== 1'b0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b A=%0d FIT=%b, want 0 0 0 0", busy, done, A, FIT);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        int qs[5] = '{3, 3, 15, 0, 0};
        int bs[5] = '{4, 5, 15, 0, 9};
        int rs[5] = '{1, 2, 15, 0, 7};
        int ea[5] = '{13, 17, 240, 0, 7};
        bit ef[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        int a, lat, bc; bit f, td;
        for (int i = 0; i < 5; i++) begin
            run_op(qs[i], bs[i], rs[i], a, f, lat, bc, td);
            checks++;
            if (a !== ea[i] || f !== ef[i]) begin
                errors++;
                $display("FAIL directed_%0d: A=%0d FIT=%b, want A=%0d FIT=%b", i, a, f, ea[i], ef[i]);
            end
            checks++;
            if (lat != N || bc != N) begin
                errors++;
                $display("FAIL latency_%0d: done after %0d edges, busy %0d cycles, want %0d/%0d", i, lat, bc, N, N);
            end
            checks++;
            if (td !== 1'b0) begin
                errors++;
                $display("FAIL done_pulse_%0d: done still %b next cycle, want 0", i, td);
            end
        end
    endtask

    task automatic test_random();
        int q, b, r, a, lat, bc; bit f, td;
        for (int i = 0; i < 60; i++) begin
            q = int'($urandom_range(15)); b = int'($urandom_range(15)); r = int'($urandom_range(15));
            run_op(q, b, r, a, f, lat, bc, td);
            checks++;
            if (a !== model_a(q, b, r) || f !== model_fit(q, b, r) || lat != N) begin
                errors++;
                $display("FAIL random q=%0d b=%0d r=%0d: A=%0d FIT=%b lat=%0d, want A=%0d FIT=%b lat=%0d",
                         q, b, r, a, f, lat, model_a(q, b, r), model_fit(q, b, r), N);
            end
        end
    endtask

    // start held high: accepts happen every N+2 cycles, other operands ignored.
    task automatic test_back_to_back();
        int qv[32], bv[32], rv[32];
        int last_a, exp_a, src;
        bit exp_done;
        int pulses = 0;
        for (int c = 0; c < 32; c++) begin
            qv[c] = int'($urandom_range(15)); bv[c] = int'($urandom_range(15)); rv[c] = int'($urandom_range(15));
        end
        @(negedge clk);
        last_a = int'(A);
        for (int c = 0; c < 30; c++) begin
            Q = N'(qv[c]); B = N'(bv[c]); R = N'(rv[c]); start = 1'b1;
            @(posedge clk); #1;
            @(negedge clk);
            exp_done = ((c % (N + 2)) == N);
            checks++;
            if (done !== exp_done) begin
                errors++;
                $display("FAIL b2b_done cyc=%0d: done=%b, want %b", c, done, exp_done);
            end
            if (exp_done) begin
                pulses++;
                src = c - N;
                exp_a = model_a(qv[src], bv[src], rv[src]);
                checks++;
                if (A !== 8'(exp_a)) begin
                    errors++;
                    $display("FAIL b2b_result cyc=%0d: A=%0d, want %0d", c, A, exp_a);
                end
                last_a = exp_a;
            end else begin
                checks++;
                if (A !== 8'(last_a)) begin
                    errors++;
                    $display("FAIL b2b_hold cyc=%0d: A=%0d, want %0d", c, A, last_a);
                end
            end
        end
        start = 1'b0;
        repeat (3) @(posedge clk);
        checks++;
        if (pulses != 5) begin
            errors++;
            $display("FAIL b2b_count: %0d pulses, want 5", pulses);
        end
    endtask

    task automatic test_reset_mid_calc();
        int a, lat, bc; bit f, td;
        bit seen = 1'b0;
        @(negedge clk);
        Q = 4'd7; B = 4'd7; R = 4'd0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (A !== 8'h00 || FIT !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: A=%0d FIT=%b busy=%b done=%b, want 0 0 0 0", A, FIT, busy, done);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL aborted_op: activity after reset release, want none");
        end
        run_op(2, 6, 3, a, f, lat, bc, td);
        checks++;
        if (a !== 15 || f !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_op: A=%0d FIT=%b, want A=15 FIT=1", a, f);
        end
    endtask

    task automatic test_sweep();
        int a, lat, bc; bit f, td;
        for (int q = 0; q < 16; q++)
            for (int b = 0; b < 16; b++)
                for (int r = 0; r < 16; r++) begin
                    run_op(q, b, r, a, f, lat, bc, td);
                    checks++;
                    if (a !== model_a(q, b, r) || f !== model_fit(q, b, r)) begin
                        errors++;
                        $display("FAIL sweep q=%0d b=%0d r=%0d: A=%0d FIT=%b, want A=%0d FIT=%b",
                                 q, b, r, a, f, model_a(q, b, r), model_fit(q, b, r));
                    end
                end
    endtask

    // Divide with the language operators, then rebuild through the DUT.
    task automatic test_divider_roundtrip();
        int a, lat, bc; bit f, td;
        for (int b = 1; b < 16; b++)
            for (int d = 0; d < 16; d++) begin
                run_op(d / b, b, d % b, a, f, lat, bc, td);
                checks++;
                if (a !== d || f !== 1'b1) begin
                    errors++;
                    $display("FAIL roundtrip d=%0d b=%0d: A=%0d FIT=%b, want A=%0d FIT=1", d, b, a, f, d);
                end
            end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_calc();
        test_sweep();
        test_divider_roundtrip();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
